// File: rtl/lab2_proc_bypass_scoreboard_if.sv
// Decode-side bundle between D and the bypass scoreboard: D instruction, pipeline
// enables and flush in, per-source bypass selects, stall and stall counter out.
interface lab2_proc_bypass_scoreboard_if #(
   parameter int unsigned NSTAGES = 3,
   parameter int unsigned NSRC    = 2,
   parameter int unsigned SELW    = $clog2(NSTAGES + 1),
   parameter int unsigned KW      = $clog2(NSTAGES)
);
   logic                 d_val;
   logic [NSRC-1:0]      d_src_en;
   logic [5*NSRC-1:0]    d_src_addr;
   logic                 d_go;
   logic                 d_wen;
   logic [4:0]           d_waddr;
   logic [KW-1:0]        d_rdy_stage;
   logic [NSTAGES-1:0]   stage_reg_en;
   logic                 flush;
   logic [SELW*NSRC-1:0] byp_sel;
   logic                 d_stall;
   logic [31:0]          stall_count;

   modport master (
      output d_val, d_src_en, d_src_addr, d_go, d_wen, d_waddr, d_rdy_stage,
      output stage_reg_en, flush,
      input  byp_sel, d_stall, stall_count
   );

   modport slave (
      input  d_val, d_src_en, d_src_addr, d_go, d_wen, d_waddr, d_rdy_stage,
      input  stage_reg_en, flush,
      output byp_sel, d_stall, stall_count
   );
endinterface

// File: rtl/lab2_proc_bypass_scoreboard.sv
// Hazard/bypass scoreboard: tracks in-flight RF writes per downstream stage and picks,
// per source operand, RF read, bypass from the youngest matching stage, or stall.
module lab2_proc_bypass_scoreboard #(
   parameter int unsigned NSTAGES   = 3,
   parameter int unsigned NSRC      = 2,
   parameter bit          BYPASS_EN = 1'b1,
   parameter int unsigned SELW      = $clog2(NSTAGES + 1),
   parameter int unsigned KW        = $clog2(NSTAGES)
) (
   input logic                         clk,
   input logic                         reset,
   lab2_proc_bypass_scoreboard_if.slave bus
);

   logic [NSTAGES-1:0]   val_q;
   logic [NSTAGES-1:0]   wen_q;
   logic [4:0]           waddr_q [NSTAGES];
   logic [KW-1:0]        rdy_q   [NSTAGES];
   logic [31:0]          stall_count_q;

   logic [NSRC-1:0]      found;
   logic [NSRC-1:0]      hazard;
   logic [SELW*NSRC-1:0] byp_sel;
   logic                 d_stall;

   // Only val needs clearing; payload is ignored while val is low.
   always_ff @(posedge clk) begin
      if (!reset) begin
         val_q         <= '0;
         stall_count_q <= '0;
      end else begin
         if (d_stall) begin
            stall_count_q <= stall_count_q + 32'd1;
         end
         if (bus.flush) begin
            val_q <= '0;
         end else begin
            if (bus.stage_reg_en[0]) begin
               val_q[0] <= bus.d_go;
            end
            for (int k = 1; k < NSTAGES; k++) begin
               // A stalled predecessor hands a bubble to a moving successor.
               if (bus.stage_reg_en[k]) begin
                  val_q[k] <= val_q[k-1] & bus.stage_reg_en[k-1];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (bus.stage_reg_en[0]) begin
         wen_q[0]   <= bus.d_wen;
         waddr_q[0] <= bus.d_waddr;
         rdy_q[0]   <= bus.d_rdy_stage;
      end
      for (int k = 1; k < NSTAGES; k++) begin
         if (bus.stage_reg_en[k]) begin
            wen_q[k]   <= wen_q[k-1];
            waddr_q[k] <= waddr_q[k-1];
            rdy_q[k]   <= rdy_q[k-1];
         end
      end
   end

   // Scan from X outward; the first match is the youngest and masks all older ones.
   always_comb begin
      found   = '0;
      hazard  = '0;
      byp_sel = '0;
      for (int i = 0; i < NSRC; i++) begin
         for (int k = 0; k < NSTAGES; k++) begin
            if (!found[i] && val_q[k] && wen_q[k] && bus.d_src_en[i] &&
                (waddr_q[k] == bus.d_src_addr[5*i +: 5]) && (waddr_q[k] != 5'd0)) begin
               found[i] = 1'b1;
               if (BYPASS_EN && (k >= int'(rdy_q[k]))) begin
                  byp_sel[SELW*i +: SELW] = SELW'(k + 1);
               end else begin
                  hazard[i] = 1'b1;
               end
            end
         end
      end
   end

   assign d_stall         = bus.d_val & (|hazard);
   assign bus.d_stall     = d_stall;
   assign bus.byp_sel     = byp_sel;
   assign bus.stall_count = stall_count_q;

endmodule

// File: doc/lab2_proc_bypass_scoreboard.md
# lab2_proc_bypass_scoreboard

Parametrised hazard and bypass control unit for the PISA pipelined processor. It sits between the decode stage and the downstream stages, which number `NSTAGES` (default X, M, W). It tracks every in-flight register write and tells D, for each source operand, whether to read the register file or bypass from a later stage, or whether D must stall. This replaces the stall-only hazard logic of the 5-stage base control. It adds load-use-aware bypassing, a configurable number of stages and sources, a stall-only compatibility mode, and a stall-cycle counter.

## Interface
Parameters:
- `NSTAGES`, 3: number of tracked stages after D; stage k=0 is X, k=NSTAGES-1 is W.
- `NSRC`, 2: source operands per instruction (rs, rt).
- `BYPASS_EN`, 1: 1 = bypass when the result is ready; 0 = stall on any match (base-pipeline behaviour).
- `SELW`, $clog2(NSTAGES+1): width of each bypass select.
- `KW`, $clog2(NSTAGES): width of stage indices.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low: state clears on a posedge where `reset`==0.
- `d_val`  in  1  D holds a valid instruction.
- `d_src_en`  in  NSRC  per-source read enable.
- `d_src_addr`  in  5*NSRC  source register specifiers; source i is in bits [5i+4:5i].
- `d_go`  in  1  D instruction advances into X this cycle.
- `d_wen`  in  1  D instruction writes the RF.
- `d_waddr`  in  5  destination register.
- `d_rdy_stage`  in  KW  first stage k whose output carries the result (0 = ALU in X, 1 = load in M).
- `stage_reg_en`  in  NSTAGES  pipeline register enable of stage k.
- `flush`  in  1  invalidate all tracked entries.
- `byp_sel`  out  SELW*NSRC  per source: 0 = register file, k+1 = bypass from stage k.
- `d_stall`  out  1  D must stall on a data hazard.
- `stall_count`  out  32  number of cycles in which `d_stall`==1.

## Operation
- Each stage k holds one entry: {val, wen, waddr, rdy_stage}. An entry *matches* source i when all of the following hold: val, wen, `d_src_en[i]`, waddr==`d_src_addr[i]`, and waddr!=0.
- Entry update each posedge, in priority order: reset, then flush, then advance.
  - Reset or flush: every val is cleared to 0.
  - Stage 0 with `stage_reg_en[0]`==1: loads {`d_go`, `d_wen`, `d_waddr`, `d_rdy_stage`}. When `d_go`==0 it loads a bubble (val=0).
  - Stage k>0 with `stage_reg_en[k]`==1: loads the entry of stage k-1 if `stage_reg_en[k-1]`==1. If `stage_reg_en[k-1]`==0 (stage k-1 is stalled), it loads a bubble.
  - Stage k with `stage_reg_en[k]`==0: holds its entry.
- Per source i, the *youngest* match is the one with the lowest k.
  - No match: `byp_sel`=0, no hazard.
  - `BYPASS_EN`=1: if k ≥ rdy_stage, `byp_sel`=k+1 and there is no hazard; otherwise hazard, and `byp_sel` is 0.
  - `BYPASS_EN`=0: any match is a hazard; `byp_sel` is always 0.
  - Older matches are always ignored.
- `d_stall` = `d_val` && (hazard on any source).
- The block does not gate `d_go` with `d_stall`; the caller must. If `d_go`==1 and `stage_reg_en[0]`==1, the entry is captured regardless of `d_stall`.
- `stall_count` increments by 1 on each posedge where `d_stall`==1, and wraps from 2^32-1 to 0. Flush does not clear it.

## Timing
- `byp_sel` and `d_stall` are combinational from the current entries and the D inputs, so the decision is made in the same cycle. There are no registered outputs apart from `stall_count`.
- An entry is visible to the next D instruction one cycle after `d_go`.
- The last stage writes the RF at the end of its cycle. A source that matches only in the last stage is bypassed from it, not read from the RF. The entry disappears once its stage loads a bubble or the next instruction.
- Reset values: all entries val=0; `byp_sel`=0; `d_stall`=0; `stall_count`=0. Reset asserted mid-operation discards all in-flight entries within one cycle.
- When flush and `d_go` occur in the same cycle, flush wins and stage 0 becomes a bubble.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles, then release. Present `d_val`=1, src0=5 enabled → `byp_sel`=0, `d_stall`=0, `stall_count`=0.
- **ALU back-to-back:** cycle 0: `d_go`=1, `d_wen`=1, `d_waddr`=3, `d_rdy_stage`=0, all enables 1. Cycle 1: src0=3 → `byp_sel[0]`=1, `d_stall`=0. Cycle 2 (no new write): `byp_sel[0]`=2. Cycle 3: 3. Cycle 4: 0.
- **Load-use:** load writing r4 with `d_rdy_stage`=1. Next cycle src1=4 → `d_stall`=1. One cycle later the entry is in M with stage 0 holding a bubble → `byp_sel[1]`=2, `d_stall`=0, `stall_count`=1.
- **Youngest wins and r0:**
  - r7 in stage 1 and r7 in stage 0, both ready → `byp_sel`=1.
  - A write to r0 (`d_wen`=1) followed by src0=0 → `byp_sel`=0, no stall.
- **Hold during stall:** `stage_reg_en`=3'b000 for 3 cycles with the load from the load-use test in stage 0 → entry held, `d_stall`=1 for all 3 cycles, `stall_count` +3.
- **Stall-only mode and flush:**
  - `BYPASS_EN`=0, ALU writes r3 → src=3 stalls for 3 cycles (entry in X, M, W), then `byp_sel`=0 and `d_stall`=0.
  - Separately, `flush`=1 with entries in all stages → next cycle no source matches.
